// File: rtl/mlp_sched_pkg.sv
// mlp_sched_pkg: shared types and widths for the MLP job scheduler
package mlp_sched_pkg;
    localparam int XW_DEF = 16;
    localparam int PROB_W = 7;
    typedef enum logic [1:0] {IDLE, WAIT, LEARN, DONE} state_e;
    typedef enum logic {TRAIN, INFER} job_e;
endpackage

// File: rtl/mlp_job_scheduler_if.sv
// mlp_job_scheduler_if: requester, result and MLP-side signals of the job scheduler
interface mlp_job_scheduler_if
    import mlp_sched_pkg::*;
#(
    parameter int XW = XW_DEF
);
    logic              train_valid;
    logic              train_ready;
    logic [XW-1:0]     train_x;
    logic              train_is_O;
    logic              infer_req;
    logic [XW-1:0]     infer_x;
    logic              infer_done;
    logic              res_valid;
    logic              res_y;
    logic [PROB_W-1:0] res_prob;
    logic              infer_overrun;
    logic [15:0]       train_count;
    logic              busy;
    logic [XW-1:0]     nn_x;
    logic              nn_learn;
    logic              nn_is_O;
    logic              nn_y;
    logic [PROB_W-1:0] nn_prob;

    modport master (
        output train_valid, train_x, train_is_O, infer_req, infer_x, nn_y, nn_prob,
        input  train_ready, infer_done, res_valid, res_y, res_prob, infer_overrun,
               train_count, busy, nn_x, nn_learn, nn_is_O
    );
    modport slave (
        input  train_valid, train_x, train_is_O, infer_req, infer_x, nn_y, nn_prob,
        output train_ready, infer_done, res_valid, res_y, res_prob, infer_overrun,
               train_count, busy, nn_x, nn_learn, nn_is_O
    );
endinterface

// File: rtl/infer_req_latch.sv
// infer_req_latch: holds one pending inference request; a new request beats a same-cycle clear
module infer_req_latch #(
    parameter int XW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_i,
    input  logic [XW-1:0] x_i,
    input  logic          clr_i,
    output logic          pend_o,
    output logic [XW-1:0] pend_x_o,
    output logic          overrun_o
);
    logic          pend_q;
    logic [XW-1:0] pend_x_q;
    logic          overrun_q;

    // A request consumed by the FSM this cycle is not lost, so it is not an overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= 1'b0;
            pend_x_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (set_i) begin
                pend_q   <= 1'b1;
                pend_x_q <= x_i;
            end else if (clr_i) begin
                pend_q <= 1'b0;
            end
            if (set_i && pend_q && !clr_i) overrun_q <= 1'b1;
        end
    end

    assign pend_o    = pend_q;
    assign pend_x_o  = pend_x_q;
    assign overrun_o = overrun_q;
endmodule

// File: rtl/mlp_job_scheduler.sv
// mlp_job_scheduler: serialises training and inference jobs onto one MLP,
// holding its input for the settling latency and capturing inference results
module mlp_job_scheduler
    import mlp_sched_pkg::*;
#(
    parameter int XW     = XW_DEF,
    parameter int NN_LAT = 4
) (
    input logic                clk,
    input logic                rst,
    mlp_job_scheduler_if.slave bus
);
    localparam logic [3:0] CNT_INIT = 4'(NN_LAT - 1);

    state_e            state_q, state_d;
    job_e              job_q, job_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              lbl_q, lbl_d;
    logic [XW-1:0]     nn_x_q, nn_x_d;
    logic              res_y_q, res_y_d;
    logic [PROB_W-1:0] res_prob_q, res_prob_d;
    logic              res_valid_q, res_valid_d;
    logic [15:0]       train_count_q, train_count_d;
    logic              pend, pend_clr, overrun, train_ready;
    logic [XW-1:0]     pend_x;

    infer_req_latch #(.XW(XW)) u_latch (
        .clk      (clk),
        .rst      (rst),
        .set_i    (bus.infer_req),
        .x_i      (bus.infer_x),
        .clr_i    (pend_clr),
        .pend_o   (pend),
        .pend_x_o (pend_x),
        .overrun_o(overrun)
    );

    // Gated by rst so every output reads 0 while reset is held
    assign train_ready = rst && state_q == IDLE && !pend && !bus.infer_req;

    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        cnt_d         = cnt_q;
        lbl_d         = lbl_q;
        nn_x_d        = nn_x_q;
        res_y_d       = res_y_q;
        res_prob_d    = res_prob_q;
        res_valid_d   = res_valid_q;
        train_count_d = train_count_q;
        pend_clr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend) begin
                    nn_x_d   = pend_x;
                    pend_clr = 1'b1;
                    job_d    = INFER;
                    cnt_d    = CNT_INIT;
                    state_d  = WAIT;
                end else if (bus.train_valid && train_ready) begin
                    nn_x_d  = bus.train_x;
                    lbl_d   = bus.train_is_O;
                    job_d   = TRAIN;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d    = job_q == TRAIN ? LEARN : DONE;
                    res_y_d    = job_q == INFER ? bus.nn_y : res_y_q;
                    res_prob_d = job_q == INFER ? bus.nn_prob : res_prob_q;
                end
            end
            LEARN: begin
                train_count_d = train_count_q + 16'd1;
                state_d       = IDLE;
            end
            DONE: begin
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            job_q         <= TRAIN;
            cnt_q         <= '0;
            lbl_q         <= 1'b0;
            nn_x_q        <= '0;
            res_y_q       <= 1'b0;
            res_prob_q    <= '0;
            res_valid_q   <= 1'b0;
            train_count_q <= '0;
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            cnt_q         <= cnt_d;
            lbl_q         <= lbl_d;
            nn_x_q        <= nn_x_d;
            res_y_q       <= res_y_d;
            res_prob_q    <= res_prob_d;
            res_valid_q   <= res_valid_d;
            train_count_q <= train_count_d;
        end
    end

    assign bus.train_ready   = train_ready;
    assign bus.busy          = state_q != IDLE;
    assign bus.nn_x          = nn_x_q;
    assign bus.nn_learn      = state_q == LEARN;
    assign bus.nn_is_O       = state_q == LEARN && lbl_q;
    assign bus.infer_done    = state_q == DONE;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_y         = res_y_q;
    assign bus.res_prob      = res_prob_q;
    assign bus.infer_overrun = overrun;
    assign bus.train_count   = train_count_q;
endmodule

// File: tb/tb_mlp_job_scheduler.sv
// tb_mlp_job_scheduler: directed and random stimulus checked against an
// event-timeline reference model (job start cycle, fixed job length)
module tb_mlp_job_scheduler;
    localparam int XW     = 16;
    localparam int NN_LAT = 4;

    logic clk;
    logic rst;
    mlp_job_scheduler_if #(.XW(XW)) bus ();

    mlp_job_scheduler #(.XW(XW), .NN_LAT(NN_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int t = 0, free_at = 0, job_start = 0, m_acc = 0, n_learn = 0, last_learn = 0;
    bit gap_chk = 0;
    bit job_inf = 0, job_lbl = 0, m_pend = 0, m_ovr = 0, m_res_y = 0, m_res_valid = 0;
    logic [XW-1:0] m_pend_x = '0, m_nn_x = '0;
    logic [6:0] m_res_prob = '0;
    logic [15:0] m_count = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.train_valid = 0; bus.train_x = '0; bus.train_is_O = 0;
        bus.infer_req = 0; bus.infer_x = '0;
    endtask

    // One clock cycle: inputs already driven; compare at negedge, then advance the model
    task automatic tick();
        bit idle, at_end, e_rdy, e_learn, e_done, consumed;
        idle    = t >= free_at;
        e_rdy   = idle && !m_pend && !bus.infer_req;
        at_end  = !idle && t == job_start + NN_LAT + 1;
        e_learn = at_end && !job_inf;
        e_done  = at_end && job_inf;
        @(negedge clk);
        chk("train_ready", bus.train_ready, e_rdy);
        chk("busy", bus.busy, !idle);
        chk("nn_learn", bus.nn_learn, e_learn);
        chk("nn_is_O", bus.nn_is_O, e_learn && job_lbl);
        chk("infer_done", bus.infer_done, e_done);
        chk("nn_x", bus.nn_x, m_nn_x);
        chk("res_valid", bus.res_valid, m_res_valid);
        chk("res_y", bus.res_y, m_res_y);
        chk("res_prob", bus.res_prob, m_res_prob);
        chk("infer_overrun", bus.infer_overrun, m_ovr);
        chk("train_count", bus.train_count, m_count);
        if (bus.nn_learn) begin
            if (gap_chk && n_learn > 0) chk("learn_gap", t - last_learn, NN_LAT + 2);
            last_learn = t;
            n_learn++;
        end
        if (!idle && job_inf && t == job_start + NN_LAT) begin
            m_res_y = bus.nn_y;
            m_res_prob = bus.nn_prob;
        end
        if (e_learn) m_count++;
        if (e_done) m_res_valid = 1;
        consumed = idle && m_pend;
        if (consumed) begin
            job_inf = 1; job_start = t; free_at = t + NN_LAT + 2;
            m_nn_x = m_pend_x; m_pend = 0;
        end else if (e_rdy && bus.train_valid) begin
            job_inf = 0; job_lbl = bus.train_is_O; job_start = t; free_at = t + NN_LAT + 2;
            m_nn_x = bus.train_x; m_acc++;
        end
        if (bus.infer_req) begin
            if (m_pend) m_ovr = 1;
            m_pend = 1;
            m_pend_x = bus.infer_x;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, bus.train_ready, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_learn"}, bus.nn_learn, 0);
        chk({tag, "_is_O"}, bus.nn_is_O, 0);
        chk({tag, "_done"}, bus.infer_done, 0);
        chk({tag, "_nn_x"}, bus.nn_x, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_y"}, bus.res_y, 0);
        chk({tag, "_res_prob"}, bus.res_prob, 0);
        chk({tag, "_overrun"}, bus.infer_overrun, 0);
        chk({tag, "_count"}, bus.train_count, 0);
    endtask

    task automatic model_reset();
        free_at = t; m_pend = 0; m_pend_x = '0; m_ovr = 0; m_nn_x = '0;
        m_res_y = 0; m_res_prob = '0; m_res_valid = 0; m_count = '0;
    endtask

    initial begin
        idle_inputs();
        bus.nn_y = 0; bus.nn_prob = '0;
        rst = 1;
        #2 rst = 0;
        #1 chk_all_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        model_reset();
        run(2);

        // Single training sample
        bus.train_valid = 1; bus.train_x = 16'h8421; bus.train_is_O = 1;
        tick();
        idle_inputs();
        run(7);

        // Inference with the network reporting O at 87%
        bus.nn_y = 1; bus.nn_prob = 7'd87;
        bus.infer_req = 1; bus.infer_x = 16'h0F0F;
        tick();
        idle_inputs();
        run(8);
        chk("infer_res_y", bus.res_y, 1);
        chk("infer_res_prob", bus.res_prob, 87);

        // Conflict: inference and training offered together
        bus.nn_y = 0; bus.nn_prob = 7'd33;
        bus.infer_req = 1; bus.infer_x = 16'h00AA;
        bus.train_valid = 1; bus.train_x = 16'h5555; bus.train_is_O = 0;
        tick();
        bus.infer_req = 0;
        for (int i = 0; i < 20 && bus.train_valid; i++) begin
            if (t >= free_at && !m_pend) begin
                tick();
                bus.train_valid = 0;
            end else tick();
        end
        run(8);

        // Overrun: two requests during one training job
        bus.train_valid = 1; bus.train_x = 16'h1234; bus.train_is_O = 1;
        tick();
        bus.train_valid = 0;
        bus.infer_req = 1; bus.infer_x = 16'h0001;
        tick();
        bus.infer_x = 16'h0002;
        tick();
        bus.infer_req = 0;
        run(4);
        chk("ovr_nn_x", bus.nn_x, 16'h0002);
        run(10);
        chk("ovr_flag", bus.infer_overrun, 1);

        // Reset dropped in the middle of a training WAIT
        bus.train_valid = 1; bus.train_x = 16'hBEEF; bus.train_is_O = 1;
        tick();
        bus.train_valid = 0;
        run(2);
        #3 rst = 0;
        #1 chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        run(8);

        // Back-to-back training stream
        gap_chk = 1; n_learn = 0; m_acc = 0;
        bus.train_valid = 1;
        for (int i = 0; i < 2000 && m_acc < 200; i++) begin
            bus.train_x = 16'($urandom); bus.train_is_O = 1'($urandom);
            tick();
        end
        bus.train_valid = 0;
        run(8);
        gap_chk = 0;
        chk("stream_learns", n_learn, 200);
        chk("stream_count", bus.train_count, 200);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.train_valid = ($urandom % 3) != 0;
            bus.train_x = 16'($urandom);
            bus.train_is_O = 1'($urandom);
            bus.infer_req = ($urandom % 12) == 0;
            bus.infer_x = 16'($urandom);
            bus.nn_y = 1'($urandom);
            bus.nn_prob = 7'($urandom_range(0, 100));
            tick();
        end
        idle_inputs();
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mlp_job_scheduler.md
# mlp_job_scheduler

Arbiter and sequencer that shares the single `mlp_OX` O/X classifier between two requesters: the training stream from `train_controller` and user inference requests raised on submit. It replaces the static training/inference multiplexer in the top level. It serialises jobs, holds the MLP input stable for the network's settling latency, and issues the one-cycle learn strobe for training samples. For inference jobs it captures the classification result and its probability and exposes them to the LED and 7-segment logic.

## Interface
Parameters:
- `XW`, 16: input flag vector width (keypad + buttons).
- `NN_LAT`, 4: cycles `nn_x` must be held before `nn_y`/`nn_prob` are valid; legal range 1..15.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-low reset.
- `train_valid`  in  1  training sample offered.
- `train_ready`  out  1  scheduler accepts the training sample this cycle.
- `train_x`  in  XW  training input pattern.
- `train_is_O`  in  1  training label, 1 = O.
- `infer_req`  in  1  single-cycle inference request (submit edge).
- `infer_x`  in  XW  inference pattern, sampled with `infer_req`.
- `infer_done`  out  1  one-cycle pulse when the inference result is updated.
- `res_valid`  out  1  sticky; set with `infer_done`.
- `res_y`  out  1  captured classification, 1 = O.
- `res_prob`  out  7  captured O probability, 0..100.
- `infer_overrun`  out  1  sticky; a pending inference was overwritten.
- `train_count`  out  16  number of completed training samples.
- `busy`  out  1  state is not IDLE.
- `nn_x`  out  XW  MLP input.
- `nn_learn`  out  1  MLP learn strobe.
- `nn_is_O`  out  1  MLP label.
- `nn_y`  in  1  MLP output.
- `nn_prob`  in  7  MLP probability output.

## Operation
- All outputs reset to 0. Reset also clears the pending register, `pend_x`, the state (to IDLE) and the latency counter. Reset asserted mid-job drops `nn_learn` immediately, and the job is lost.
- Pending latch:
  - `infer_req` sets `pend` and loads `pend_x <= infer_x` in any state.
  - If `pend` is already 1, `pend_x` is overwritten (latest request wins) and `infer_overrun` is set.
- `train_ready` is combinational and equals `IDLE && !pend && !infer_req`. Inference always wins a simultaneous conflict.
- FSM states: IDLE, WAIT, LEARN, DONE.
  - **IDLE, with `pend` = 1:**
    - `nn_x <= pend_x`, `pend <= 0`, `job <= INFER`.
    - Counter is set to `NN_LAT-1`, then go to WAIT.
    - If `infer_req` arrives in this same cycle, it re-sets `pend` with the new data.
  - **IDLE, else if `train_valid && train_ready`:**
    - `nn_x <= train_x`, `lbl <= train_is_O`, `job <= TRAIN`.
    - Counter is set to `NN_LAT-1`, then go to WAIT.
  - **WAIT:**
    - Decrement the counter.
    - At counter 0: a TRAIN job goes to LEARN. An INFER job captures `res_y <= nn_y` and `res_prob <= nn_prob`, then goes to DONE.
  - **LEARN:**
    - `nn_learn` = 1 and `nn_is_O` = `lbl` for exactly this cycle.
    - `train_count` increments and wraps 0xFFFF to 0.
    - Go to IDLE.
  - **DONE:** `infer_done` = 1 and `res_valid <= 1`, then go to IDLE.
- `nn_learn` and `nn_is_O` are 0 in every state except LEARN.
- `nn_x` holds its last value while in IDLE, so the network never sees a glitching input.
- `res_*` outputs change only on the INFER capture. `res_valid` is never cleared except by reset.

## Timing
- Training sample accepted at cycle T:
  - WAIT spans T+1..T+NN_LAT.
  - `nn_learn` is high at T+NN_LAT+1.
  - `train_ready` can be high again at T+NN_LAT+2.
  - Throughput is one sample per NN_LAT+2 cycles, i.e. 6 cycles with defaults.
- `infer_req` at cycle T with the scheduler idle:
  - `pend` = 1 at T+1.
  - `nn_x` updates and WAIT spans T+2..T+1+NN_LAT.
  - `res_*` and `infer_done` appear at T+2+NN_LAT.
  - IDLE again at T+3+NN_LAT.
- `infer_req` while busy: the inference is served on the first IDLE cycle after the current job, before any further training sample.
- `train_valid` may drop without acceptance; no state is consumed until the handshake completes.

## Structure
- Package `mlp_sched_pkg` holds:
  - the state enum (IDLE/WAIT/LEARN/DONE);
  - the job enum (TRAIN/INFER);
  - `XW_DEF` = 16;
  - `PROB_W` = 7.
- One sub-module, `infer_req_latch`, containing `pend`, `pend_x` and the overrun logic. It has a clear input driven by the FSM, and clear-plus-set in the same cycle results in set.
- The FSM, latency counter, result registers and `train_count` stay in the top of this block.

## Test plan
- **Reset:** drive `rst` = 0 mid-WAIT. Required: all outputs 0 at once, `nn_learn` never pulses, and state is IDLE after release.
- **Single training sample:** `train_valid` = 1 at T, `train_x` = 0x8421, `train_is_O` = 1. Required: `nn_x` = 0x8421 at T+1, `nn_learn` = 1 and `nn_is_O` = 1 only at T+5, `train_count` = 1, `train_ready` = 1 at T+6.
- **Inference:** `infer_req` at T, `infer_x` = 0x0F0F, model returns `nn_y` = 1 and `nn_prob` = 87. Required: `infer_done` pulse at T+6, `res_y` = 1, `res_prob` = 87, `res_valid` = 1.
- **Conflict:** `infer_req` and `train_valid` in the same IDLE cycle. Required: `train_ready` = 0, inference served first, training accepted at the first IDLE cycle after DONE.
- **Overrun:** two `infer_req` during a training job, with x = 0x0001 then 0x0002. Required: `infer_overrun` = 1 and one inference only, with `nn_x` = 0x0002.
- **Stream:** 200 back-to-back training samples. Required: `train_count` = 200, exactly 200 learn pulses, each spaced 6 cycles apart.
